multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 32 +++
 rtl/multicycle_ctrl_pc_unit.sv | 38 +++
 rtl/multicycle_ctrl.sv | 123 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, widths, PC step and ALU opcodes.
package multicycle_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned STATE_WIDTH        = 3;
    localparam int unsigned INSTRET_WIDTH      = 32;
    localparam int unsigned PC_INCR            = 4;

    typedef enum logic [STATE_WIDTH-1:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_op_e;

endpackage

// File: rtl/multicycle_ctrl_pc_unit.sv
// Program counter register with next-PC selection (sequential step or redirect target).
module multicycle_ctrl_pc_unit
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    // Wraps naturally modulo 2^ADDR_WIDTH.
    assign pc_plus4 = pc_q + ADDR_WIDTH'(PC_INCR);
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            pc_d = redirect ? target : pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle core controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky misalignment trap.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [ADDR_WIDTH-1:0]    dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic                     dmem_ack,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic                     is_branch,
    input  logic                     is_jump,
    input  logic                     rd_write,
    input  logic                     branch_taken,
    input  logic [ADDR_WIDTH-1:0]    branch_target,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     stall_req,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDR_WIDTH-1:0]    pc,
    output logic                     rf_we,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [STATE_WIDTH-1:0]   state,
    output logic                     trap,
    output logic [INSTRET_WIDTH-1:0] instret
);

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    ir_q, alu_q, ld_q;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic [ADDR_WIDTH-1:0]    pc_plus4;
    logic                     redirect, pc_advance;

    assign redirect = is_jump | (is_branch & branch_taken);

    multicycle_ctrl_pc_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) pc_unit (
        .clk      (clk),
        .rst      (rst),
        .advance  (pc_advance),
        .redirect (redirect),
        .target   (branch_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        pc_advance = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Reset resolves to FETCH, so the request must also be masked by rst itself.
                if (!stall_req && !rst) begin
                    imem_req = 1'b1;
                    if (imem_ack) state_d = StDecode;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (redirect && branch_target[1:0] != 2'b00) state_d = StTrap;
                else if (is_load || is_store)                  state_d = StMem;
                else                                           state_d = StWb;
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) state_d = StWb;
            end
            StWb: begin
                rf_we      = rd_write;
                rf_wdata   = is_load ? ld_q : (is_jump ? DATA_WIDTH'(pc_plus4) : alu_q);
                pc_advance = 1'b1;
                state_d    = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            alu_q     <= '0;
            ld_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (imem_req && imem_ack)              ir_q      <= imem_rdata;
            if (state_q == StExec)                 alu_q     <= alu_result;
            if (dmem_req && dmem_ack && is_load)   ld_q      <= dmem_rdata;
            if (state_q == StWb)                   instret_q <= instret_q + 1'b1;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = alu_q[ADDR_WIDTH-1:0];
    assign dmem_wdata = rs2_data;
    assign instr      = ir_q;
    assign state      = state_q;
    assign trap       = (state_q == StTrap);
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction stream.
module tb_multicycle_ctrl;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        is_load, is_store, is_branch, is_jump, rd_write, branch_taken;
    logic [9:0]  branch_target;
    logic [31:0] alu_result, rs2_data;
    logic        stall_req;
    logic [31:0] instr;
    logic [9:0]  pc;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [2:0]  state;
    logic        trap;
    logic [31:0] instret;

    int nchk  = 0;
    int nfail = 0;

    // Reference model of architectural state.
    logic [9:0]  m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_instret;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .is_load       (is_load),
        .is_store      (is_store),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .rd_write      (rd_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .alu_result    (alu_result),
        .rs2_data      (rs2_data),
        .stall_req     (stall_req),
        .instr         (instr),
        .pc            (pc),
        .rf_we         (rf_we),
        .rf_wdata      (rf_wdata),
        .state         (state),
        .trap          (trap),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        stall_req = 1'b0;
        #1;
        nchk++;
        if ({imem_req, dmem_req, dmem_we, rf_we, trap, pc, instr, instret} !==
            {5'b00000, 10'h000, 32'h0, 32'h0}) begin
            nfail++;
            $display("FAIL reset_state: req/we/trap=%b%b%b%b%b pc=%h ir=%h instret=%h, want all zero",
                     imem_req, dmem_req, dmem_we, rf_we, trap, pc, instr, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pc = 10'h000;
        m_ir = 32'h0;
        m_instret = 32'h0;
        #1;
        nchk++;
        if ({imem_req, imem_addr} !== {1'b1, 10'h000}) begin
            nfail++;
            $display("FAIL first_fetch: req=%b addr=%h, want 1 000", imem_req, imem_addr);
        end
    endtask

    // Drives one instruction through the controller and checks every cycle against the spec rules.
    task automatic run_instr(input logic ld, st, br, jp, rdw, tk, input logic [9:0] tgt,
                             input logic [31:0] alu, rs2, iw, dw,
                             input int stalls, ilat, dlat);
        logic        redir;
        logic [9:0]  pc4;
        logic [31:0] exp_wd;
        is_load = ld; is_store = st; is_branch = br; is_jump = jp; rd_write = rdw;
        branch_taken = tk; branch_target = tgt; alu_result = alu; rs2_data = rs2;
        imem_rdata = iw; dmem_rdata = dw;
        redir = jp | (br & tk);
        pc4 = m_pc + 10'd4;
        for (int c = 0; c < stalls; c++) begin
            stall_req = 1'b1;
            imem_ack = 1'($urandom_range(0, 1));
            #1;
            nchk++;
            if ({imem_req, dmem_req, instr} !== {2'b00, m_ir}) begin
                nfail++;
                $display("FAIL stall_hold: req=%b%b ir=%h, want 00 ir=%h",
                         imem_req, dmem_req, instr, m_ir);
            end
            @(negedge clk);
        end
        stall_req = 1'b0;
        for (int c = 0; c <= ilat; c++) begin
            imem_ack = (c == ilat);
            #1;
            nchk++;
            if ({imem_req, imem_addr, dmem_req, rf_we} !== {1'b1, m_pc, 2'b00}) begin
                nfail++;
                $display("FAIL fetch_req: req=%b addr=%h dreq=%b rf_we=%b state=%0d, want 1 %h 0 0",
                         imem_req, imem_addr, dmem_req, rf_we, state, m_pc);
            end
            @(negedge clk);
            if (c < ilat) begin
                nchk++;
                if (instr !== m_ir) begin
                    nfail++;
                    $display("FAIL ir_hold: ir=%h, want %h", instr, m_ir);
                end
            end
        end
        imem_ack = 1'b0;
        m_ir = iw;
        #1;
        nchk++;
        if ({instr, imem_req, dmem_req, rf_we} !== {iw, 3'b000}) begin
            nfail++;
            $display("FAIL decode: ir=%h req=%b%b rf_we=%b, want %h 000",
                     instr, imem_req, dmem_req, rf_we, iw);
        end
        @(negedge clk);
        #1;
        nchk++;
        if ({imem_req, dmem_req, rf_we} !== 3'b000) begin
            nfail++;
            $display("FAIL exec: req=%b%b rf_we=%b, want 000", imem_req, dmem_req, rf_we);
        end
        @(negedge clk);
        if (redir && tgt[1:0] != 2'b00) begin
            for (int c = 0; c < 3; c++) begin
                imem_ack = 1'($urandom_range(0, 1));
                dmem_ack = 1'($urandom_range(0, 1));
                #1;
                nchk++;
                if ({trap, imem_req, dmem_req, rf_we, pc} !== {4'b1000, m_pc}) begin
                    nfail++;
                    $display("FAIL trap: trap=%b req=%b%b rf_we=%b pc=%h, want 1 000 pc=%h",
                             trap, imem_req, dmem_req, rf_we, pc, m_pc);
                end
                @(negedge clk);
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            return;
        end
        if (ld || st) begin
            for (int c = 0; c <= dlat; c++) begin
                dmem_ack = (c == dlat);
                #1;
                nchk++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, imem_req, rf_we} !==
                    {1'b1, st, alu[9:0], rs2, 2'b00}) begin
                    nfail++;
                    $display("FAIL mem_req: req=%b we=%b addr=%h wdata=%h ireq=%b rf_we=%b, want 1 %b %h %h 0 0",
                             dmem_req, dmem_we, dmem_addr, dmem_wdata, imem_req, rf_we,
                             st, alu[9:0], rs2);
                end
                @(negedge clk);
            end
            dmem_ack = 1'b0;
        end
        exp_wd = ld ? dw : (jp ? {22'd0, pc4} : alu);
        #1;
        nchk++;
        if ({rf_we, imem_req, dmem_req} !== {rdw, 2'b00}) begin
            nfail++;
            $display("FAIL wb_we: rf_we=%b req=%b%b, want %b 00", rf_we, imem_req, dmem_req, rdw);
        end
        if (rdw) begin
            nchk++;
            if (rf_wdata !== exp_wd) begin
                nfail++;
                $display("FAIL wb_data: rf_wdata=%h, want %h", rf_wdata, exp_wd);
            end
        end
        @(negedge clk);
        m_instret = m_instret + 32'd1;
        m_pc = redir ? tgt : pc4;
        #1;
        nchk++;
        if ({pc, imem_addr, instret, trap} !== {m_pc, m_pc, m_instret, 1'b0}) begin
            nfail++;
            $display("FAIL retire: pc=%h addr=%h instret=%0d trap=%b, want %h %h %0d 0",
                     pc, imem_addr, instret, trap, m_pc, m_pc, m_instret);
        end
    endtask

    task automatic test_addi();
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 32'h0000_0005, 32'h0,
                  32'h0050_0093, 32'h0, 0, 0, 0);
    endtask

    task automatic test_imem_wait();
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 32'h1234_5678, 32'h0,
                  32'hA5A5_0013, 32'h0, 2, 3, 0);
    endtask

    task automatic test_store();
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0000_0010, 32'hDEAD_BEEF,
                  32'h0020_A823, 32'h0, 0, 0, 2);
    endtask

    task automatic test_load();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 32'h0000_0124, 32'h0,
                  32'h0001_2083, 32'hCAFE_F00D, 0, 1, 1);
    endtask

    task automatic test_jal_wrap();
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h3FC, 32'h0, 32'h0,
                  32'h3FC0_006F, 32'h0, 0, 0, 0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h008, 32'h0, 32'h0,
                  32'h0080_00EF, 32'h0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic ld, st, br, jp, rdw, tk;
            logic [9:0] tgt;
            kind = int'($urandom_range(0, 4));
            ld = (kind == 1);
            st = (kind == 2);
            br = (kind == 3);
            jp = (kind == 4);
            rdw = (st || br) ? 1'b0 : 1'($urandom_range(0, 1));
            tk = 1'($urandom_range(0, 1));
            tgt = 10'($urandom_range(0, 255) << 2);
            run_instr(ld, st, br, jp, rdw, tk, tgt, $urandom(), $urandom(), $urandom(),
                      $urandom(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_trap();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h00A, 32'h0, 32'h0,
                  32'h0000_0463, 32'h0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_mem();
        is_load = 1'b1; is_store = 1'b0; is_branch = 1'b0; is_jump = 1'b0; rd_write = 1'b1;
        alu_result = 32'h0000_0020;
        imem_rdata = 32'h0200_2103;
        dmem_ack = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        nchk++;
        if ({dmem_req, dmem_addr} !== {1'b1, 10'h020}) begin
            nfail++;
            $display("FAIL mem_wait: dreq=%b addr=%h, want 1 020", dmem_req, dmem_addr);
        end
        rst = 1'b1;
        #1;
        nchk++;
        if ({dmem_req, dmem_we, imem_req, rf_we, trap, pc, instr, instret} !==
            {5'b00000, 10'h000, 32'h0, 32'h0}) begin
            nfail++;
            $display("FAIL async_reset: req/we/trap=%b%b%b%b%b pc=%h ir=%h instret=%h, want all zero",
                     dmem_req, dmem_we, imem_req, rf_we, trap, pc, instr, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pc = 10'h000;
        m_ir = 32'h0;
        m_instret = 32'h0;
        #1;
        nchk++;
        if ({imem_req, imem_addr, instret} !== {1'b1, 10'h000, 32'h0}) begin
            nfail++;
            $display("FAIL refetch: req=%b addr=%h instret=%0d, want 1 000 0",
                     imem_req, imem_addr, instret);
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jump = 1'b0; rd_write = 1'b0;
        branch_taken = 1'b0; branch_target = '0; alu_result = '0; rs2_data = '0;
        stall_req = 1'b0;
        m_pc = '0; m_ir = '0; m_instret = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_addi();
        test_imem_wait();
        test_store();
        test_load();
        test_jal_wrap();
        test_random();
        test_trap();
        test_reset();
        test_addi();
        test_reset_mid_mem();
        test_addi();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
